// File: rtl/mips_bp_pkg.sv
// mips_bp_pkg -- shared types for the MIPS dynamic branch predictor.
//
// Contents:
//   ctr_t       2-bit saturating direction counter (SNT/WNT/WT/ST)
//   CTR_RESET   counter value after reset or an invalidate sweep (weak not-taken)
//   CTR_ALLOC   counter value written when a taken branch allocates an entry
//   bp_state_t  invalidate-sweep FSM states
//   ctr_predict helper returning the taken/not-taken decision of a counter
//
// Optional feature macro used by the importing files: BP_GSHARE_EN.
package mips_bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam ctr_t CTR_RESET = WNT;
  localparam ctr_t CTR_ALLOC = WT;

  typedef enum logic {
    BP_IDLE  = 1'b0,
    BP_CLEAR = 1'b1
  } bp_state_t;

  // The MSB of the counter is the direction decision.
  function automatic logic ctr_predict(input ctr_t c);
    return c[1];
  endfunction

endpackage

// File: rtl/mips_branch_predictor_sat_ctr.sv
// bp_sat_ctr -- next-state logic for one 2-bit saturating direction counter.
//
// Ports:
//   ctr_cur   in   current counter value
//   inc       in   step towards strong-taken
//   dec       in   step towards strong-not-taken
//   ctr_next  out  saturated next value (holds if neither or both steps requested)
//   predict   out  taken decision of the current value
//
// Optional feature macro: none (BP_GSHARE_EN only affects the top level).
module bp_sat_ctr
  import mips_bp_pkg::*;
(
  input  ctr_t ctr_cur,
  input  logic inc,
  input  logic dec,
  output ctr_t ctr_next,
  output logic predict
);

  always_comb begin
    ctr_next = ctr_cur;
    if (inc && !dec && ctr_cur != ST) begin
      ctr_next = ctr_t'(ctr_cur + 2'd1);
    end else if (dec && !inc && ctr_cur != SNT) begin
      ctr_next = ctr_t'(ctr_cur - 2'd1);
    end
  end

  assign predict = ctr_predict(ctr_cur);

endmodule

// File: rtl/mips_branch_predictor.sv
// mips_branch_predictor -- direct-mapped BTB plus 2-bit counters for the
// IF stage of the 5-stage MIPS pipeline.
//
// Ports:
//   clock, reset                rising-edge clock, asynchronous active-high reset
//   if_pc                       fetch PC, looked up combinationally
//   pred_taken/pred_target      prediction (target forced to 0 when not taken)
//   pred_ghr                    history snapshot to be echoed back on update
//   upd_*                       resolution event from the branch-resolving stage
//   upd_mispredict              combinational mispredict flag for the update
//   flush_req / busy            invalidate-all sweep request / sweep in progress
//   stat_lookups / stat_mispred saturating statistics counters
//
// Optional feature macro: BP_GSHARE_EN -- the counter array is indexed by
// idx XOR global history; tag/target stay indexed by the plain idx.
module mips_branch_predictor
  import mips_bp_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 16,
  parameter int HIST_W  = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  output logic [HIST_W-1:0] pred_ghr,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_is_branch,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_target,
  input  logic [HIST_W-1:0] upd_ghr,
  output logic              upd_mispredict,
  input  logic              flush_req,
  output logic              busy,
  output logic [CNT_W-1:0]  stat_lookups,
  output logic [CNT_W-1:0]  stat_mispred
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  // Tag/target storage carries no reset: valid_reg gates every use.
  logic [TAG_W-1:0]  tag_mem    [ENTRIES];
  logic [ADDR_W-1:0] target_mem [ENTRIES];

  logic valid_reg  [ENTRIES];
  logic valid_next [ENTRIES];
  ctr_t ctr_reg    [ENTRIES];
  ctr_t ctr_next   [ENTRIES];

  bp_state_t        state_reg;
  logic [IDX_W-1:0] ptr_reg;
  logic [CNT_W-1:0] lookups_reg;
  logic [CNT_W-1:0] mispred_reg;

  logic [IDX_W-1:0] lk_idx, lk_cidx, up_idx, up_cidx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit;
  logic             accept, br_hit, br_alloc, nb_inval;
  logic             ctr_we, val_we, val_wdata, mem_we;
  ctr_t             up_ctr_cur, up_ctr_next, ctr_wdata;
  logic             unused_up_predict;

  assign busy = (state_reg == BP_CLEAR);

  assign lk_idx = if_pc[IDX_W+1:2];
  assign lk_tag = if_pc[ADDR_W-1:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[ADDR_W-1:IDX_W+2];

`ifdef BP_GSHARE_EN
  logic [HIST_W-1:0] ghr_reg;
  logic [HIST_W:0]   ghr_shift;

  assign lk_cidx   = lk_idx ^ IDX_W'(ghr_reg);
  assign up_cidx   = up_idx ^ IDX_W'(upd_ghr);
  assign pred_ghr  = ghr_reg;
  assign ghr_shift = {ghr_reg, upd_taken};

  // History is restarted by a sweep so trained patterns line up with the
  // freshly reset counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ghr_reg <= '0;
    end else if (state_reg == BP_IDLE && flush_req) begin
      ghr_reg <= '0;
    end else if (accept && upd_is_branch) begin
      ghr_reg <= ghr_shift[HIST_W-1:0];
    end
  end
`else
  logic unused_ghr;

  assign lk_cidx    = lk_idx;
  assign up_cidx    = up_idx;
  assign pred_ghr   = '0;
  assign unused_ghr = ^upd_ghr;
`endif

  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0], unused_up_predict};

  // Lookup sees the pre-update state; there is deliberately no bypass.
  assign lk_hit      = valid_reg[lk_idx] && (tag_mem[lk_idx] == lk_tag);
  assign pred_taken  = lk_hit && ctr_reg[lk_cidx][1] && !busy;
  assign pred_target = pred_taken ? target_mem[lk_idx] : '0;

  // Mispredict is a pure function of the echoed prediction, so it is still
  // reported (and counted) during a sweep.
  assign upd_mispredict = upd_valid &&
                          ((upd_pred_taken != upd_taken) ||
                           (upd_taken && (upd_pred_target != upd_target)));

  assign up_hit   = valid_reg[up_idx] && (tag_mem[up_idx] == up_tag);
  assign accept   = upd_valid && !busy;
  assign br_hit   = accept && upd_is_branch && up_hit;
  assign br_alloc = accept && upd_is_branch && !up_hit && upd_taken;
  assign nb_inval = accept && !upd_is_branch && up_hit;

  assign up_ctr_cur = ctr_reg[up_cidx];

  bp_sat_ctr u_upd_ctr (
    .ctr_cur  (up_ctr_cur),
    .inc      (upd_taken),
    .dec      (!upd_taken),
    .ctr_next (up_ctr_next),
    .predict  (unused_up_predict)
  );

  assign ctr_we    = br_hit || br_alloc;
  assign ctr_wdata = br_alloc ? CTR_ALLOC : up_ctr_next;
  assign val_we    = br_alloc || nb_inval;
  assign val_wdata = br_alloc;
  // On a taken hit the tag rewrite is a no-op, so one write enable serves both.
  assign mem_we    = br_alloc || (br_hit && upd_taken);

  // Per-entry next state: the sweep pointer has priority, although updates
  // are never accepted while it runs.
  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    logic sweep_here;
    assign sweep_here     = busy && (ptr_reg == IDX_W'(gi));
    assign valid_next[gi] = sweep_here ? 1'b0 :
                            (val_we && up_idx == IDX_W'(gi)) ? val_wdata :
                            valid_reg[gi];
    assign ctr_next[gi]   = sweep_here ? CTR_RESET :
                            (ctr_we && up_cidx == IDX_W'(gi)) ? ctr_wdata :
                            ctr_reg[gi];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_reg[i] <= 1'b0;
        ctr_reg[i]   <= CTR_RESET;
      end
    end else begin
      valid_reg <= valid_next;
      ctr_reg   <= ctr_next;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      tag_mem[up_idx]    <= up_tag;
      target_mem[up_idx] <= upd_target;
    end
  end

  // Sweep FSM: one entry per cycle, exactly ENTRIES cycles in CLEAR.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= BP_IDLE;
      ptr_reg   <= '0;
    end else begin
      case (state_reg)
        BP_IDLE: begin
          if (flush_req) begin
            state_reg <= BP_CLEAR;
            ptr_reg   <= '0;
          end
        end
        BP_CLEAR: begin
          ptr_reg <= ptr_reg + 1'b1;
          if (ptr_reg == IDX_W'(ENTRIES - 1)) begin
            state_reg <= BP_IDLE;
          end
        end
        default: state_reg <= BP_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lookups_reg <= '0;
      mispred_reg <= '0;
    end else begin
      if (!busy && lookups_reg != '1) begin
        lookups_reg <= lookups_reg + 1'b1;
      end
      if (upd_mispredict && mispred_reg != '1) begin
        mispred_reg <= mispred_reg + 1'b1;
      end
    end
  end

  assign stat_lookups = lookups_reg;
  assign stat_mispred = mispred_reg;

endmodule

// File: doc/mips_branch_predictor.md
Name: mips_branch_predictor

Overview:
- Parametrised dynamic branch predictor that replaces the static, ID-stage branch decision in the 5-stage MIPS pipeline.
- Direct-mapped branch target buffer (BTB) plus 2-bit saturating counters, looked up combinationally by the IF-stage PC.
- Trained by the stage that resolves branches/jumps; reports mispredicts and keeps saturating statistics counters.
- Supports an invalidate-all sweep on request.

Parameters:
- ENTRIES, 64, BTB depth; power of two, min 4; IDX_W = $clog2(ENTRIES).
- ADDR_W, 32, PC/target width.
- CNT_W, 16, width of each statistics counter.
- HIST_W, 6, global history length; used only with BP_GSHARE_EN; must be <= IDX_W.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- if_pc  in  ADDR_W  PC being fetched.
- pred_taken  out  1  predict taken (combinational).
- pred_target  out  ADDR_W  predicted target; 0 when pred_taken=0.
- pred_ghr  out  HIST_W  history snapshot for the pipeline to echo back; 0 without macro.
- upd_valid  in  1  resolution event this cycle.
- upd_pc  in  ADDR_W  PC of the resolved instruction.
- upd_is_branch  in  1  instruction is a branch/jump.
- upd_taken  in  1  actual outcome.
- upd_target  in  ADDR_W  actual target.
- upd_pred_taken  in  1  echoed pred_taken.
- upd_pred_target  in  ADDR_W  echoed pred_target.
- upd_ghr  in  HIST_W  echoed pred_ghr.
- upd_mispredict  out  1  combinational mispredict flag.
- flush_req  in  1  start an invalidate-all sweep.
- busy  out  1  sweep in progress.
- stat_lookups  out  CNT_W  count of cycles with busy=0.
- stat_mispred  out  CNT_W  count of mispredicts.

Behaviour:
- Addressing: idx = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2]. Each entry holds valid, tag, target, 2-bit counter.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup: hit = valid[idx] && tag match. pred_taken = hit && ctr[idx][1] && !busy. pred_target = target[idx] when pred_taken, else 0. Zero latency from if_pc.
- Mispredict: upd_mispredict = upd_valid && (upd_pred_taken != upd_taken || (upd_taken && upd_pred_target != upd_target)). Evaluated even when busy=1.
- Update, applied at the posedge; ignored while busy=1:
  - upd_is_branch=1, hit: counter +1 if taken, -1 if not, saturating at 11/00. Target rewritten when taken.
  - upd_is_branch=1, miss, taken: allocate (overwrite), tag, target, counter=10, valid=1.
  - upd_is_branch=1, miss, not taken: no change.
  - upd_is_branch=0, hit: clear valid (aliasing cleanup).
- Same-cycle lookup and update of the same idx: lookup sees the pre-update state. No bypass.
- FSM with states IDLE and CLEAR:
  - IDLE -> CLEAR on flush_req; ptr=0.
  - CLEAR: clear valid[ptr] and set ctr[ptr]=01, ptr++ each cycle. Return to IDLE after ptr=ENTRIES-1, so the sweep takes exactly ENTRIES cycles.
  - busy=1 in CLEAR. flush_req while busy is ignored (no restart).
- Stats: stat_lookups +1 each cycle with busy=0; stat_mispred +1 when upd_mispredict=1. Both saturate at all-ones.
- Reset (asynchronous, any time including mid-sweep):
  - all valid=0, all counters=01, state=IDLE, ptr=0, stats=0.
  - GHR=0 under the macro.
  - outputs: pred_taken=0, pred_target=0, busy=0, pred_ghr=0.
  - Tag/target arrays need no reset.

Optional Feature:
- Macro BP_GSHARE_EN.
- Defined:
  - GHR register (HIST_W bits) shifts in upd_taken (LSB) on every accepted update with upd_is_branch=1; cleared by flush.
  - Counter index = idx XOR zero-extended GHR for lookup. The update uses idx(upd_pc) XOR upd_ghr.
  - Tag/target still use the plain idx; the counter array is separate.
  - pred_ghr = GHR.
- Undefined: counters are co-indexed with the BTB entry, pred_ghr=0, upd_ghr is ignored.

Decomposition:
- Package mips_bp_pkg: counter enum (SNT/WNT/WT/ST), CTR_RESET=WNT, CTR_ALLOC=WT, FSM state enum {BP_IDLE, BP_CLEAR}.
- Sub-module bp_sat_ctr: 2-bit saturating next-state (inc/dec/hold) plus predict bit; one instance per write port.

Test Plan:
- Reset, then if_pc=0x40 -> pred_taken=0, pred_target=0, busy=0, stats=0.
- Taken update pc=0x40, target=0x100, pred_taken=0 -> upd_mispredict=1, stat_mispred=1. Next cycle lookup 0x40 -> pred_taken=1, pred_target=0x100.
- Train 0x40: NT, NT -> counter 10->01->00, pred_taken=0. Then T, T -> 01->10, pred_taken=1. Four T updates from 11 stay at 11.
- ENTRIES=64: allocate 0x40 taken, then a taken update at 0x140 (same idx, different tag) -> 0x40 misses, 0x140 hits. Non-branch update at 0x140 -> invalidated.
- flush_req with 3 valid entries -> busy high exactly 64 cycles, pred_taken=0 and updates ignored meanwhile, all miss after. Assert reset at cycle 10 of the sweep -> busy=0 immediately.
- BP_GSHARE_EN: alternating T/NT branch at 0x80, HIST_W=2 -> after warm-up zero mispredicts over 20 iterations. Same sequence without the macro -> mispredicts recur every iteration.
